// File: rtl/rgb_dark_win_if.sv
// Video bus for the dark/bright-channel extractor: raw RGB timing in, filtered
// value plus frame-wide maximum out.
interface rgb_dark_win_if #(
  parameter int DATA_W = 8
);
  logic                  i_mode;
  logic [3*DATA_W-1:0]   i_rgb;
  logic                  i_hsync;
  logic                  i_vsync;
  logic                  i_de;
  logic [DATA_W-1:0]     o_pix;
  logic                  o_hsync;
  logic                  o_vsync;
  logic                  o_de;
  logic [DATA_W-1:0]     o_frame_max;
  logic                  o_frame_max_vld;

  modport master (
    output i_mode, i_rgb, i_hsync, i_vsync, i_de,
    input  o_pix, o_hsync, o_vsync, o_de, o_frame_max, o_frame_max_vld
  );

  modport slave (
    input  i_mode, i_rgb, i_hsync, i_vsync, i_de,
    output o_pix, o_hsync, o_vsync, o_de, o_frame_max, o_frame_max_vld
  );
endinterface

// File: rtl/rgb_dark_win.sv
// Per-pixel min/max of R,G,B followed by a centred horizontal min/max window
// over valid pixels only, plus a per-frame maximum of the filtered output.
module rgb_dark_win #(
  parameter int DATA_W = 8,
  parameter int WIN    = 3
) (
  input  logic           pixelclk,
  input  logic           reset,
  rgb_dark_win_if.slave  vid
);

  localparam int H = (WIN - 1) / 2;
  localparam int L = 3 + H;

  function automatic logic [DATA_W-1:0] pick(
    input logic              bright,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    if (bright) begin
      pick = (a > b) ? a : b;
    end else begin
      pick = (a < b) ? a : b;
    end
  endfunction

  logic                mode_r;
  logic                vs_prev_r;
  logic [DATA_W-1:0]   s1_rg_r;
  logic [DATA_W-1:0]   s1_b_r;
  logic                s1_de_r;
  // Entry 0 is the stage-2 per-pixel result; higher indices are older pixels.
  logic [DATA_W-1:0]   win_v_r   [0:WIN-1];
  logic                win_vld_r [0:WIN-1];
  // Sync delay line, bit order {hsync, vsync, de}.
  logic [2:0]          dly_r     [0:L-1];
  logic [DATA_W-1:0]   pix_r;
  logic [DATA_W-1:0]   run_max_r;
  logic [DATA_W-1:0]   frame_max_r;
  logic                frame_max_vld_r;

  logic [DATA_W-1:0]   acc_s;
  logic [DATA_W-1:0]   pix_next_s;
  logic                vs_rise_next_s;

  wire [DATA_W-1:0] r_s = vid.i_rgb[3*DATA_W-1 -: DATA_W];
  wire [DATA_W-1:0] g_s = vid.i_rgb[2*DATA_W-1 -: DATA_W];
  wire [DATA_W-1:0] b_s = vid.i_rgb[DATA_W-1   -: DATA_W];

  // Mode is captured only on the rising edge of input vsync.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      mode_r    <= 1'b0;
      vs_prev_r <= 1'b0;
    end else begin
      vs_prev_r <= vid.i_vsync;
      if (vid.i_vsync && !vs_prev_r) begin
        mode_r <= vid.i_mode;
      end else begin
        mode_r <= mode_r;
      end
    end
  end

  // Stages 1-2 and the window shift register; shifts through blanking too.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      s1_rg_r <= {DATA_W{1'b0}};
      s1_b_r  <= {DATA_W{1'b0}};
      s1_de_r <= 1'b0;
      for (int k = 0; k < WIN; k++) begin
        win_v_r[k]   <= {DATA_W{1'b0}};
        win_vld_r[k] <= 1'b0;
      end
    end else begin
      s1_rg_r      <= pick(mode_r, r_s, g_s);
      s1_b_r       <= b_s;
      s1_de_r      <= vid.i_de;
      win_v_r[0]   <= s1_de_r ? pick(mode_r, s1_rg_r, s1_b_r) : {DATA_W{1'b0}};
      win_vld_r[0] <= s1_de_r;
      for (int k = 1; k < WIN; k++) begin
        win_v_r[k]   <= win_v_r[k-1];
        win_vld_r[k] <= win_vld_r[k-1];
      end
    end
  end

  // Window reduction over valid taps; an invalid centre forces zero.
  always_comb begin
    acc_s = win_v_r[H];
    for (int i = 0; i < WIN; i++) begin
      acc_s = win_vld_r[i] ? pick(mode_r, acc_s, win_v_r[i]) : acc_s;
    end
    pix_next_s     = win_vld_r[H] ? acc_s : {DATA_W{1'b0}};
    vs_rise_next_s = dly_r[L-2][1] & ~dly_r[L-1][1];
  end

  // Sync delay line and registered pixel output.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      for (int k = 0; k < L; k++) begin
        dly_r[k] <= 3'b000;
      end
      pix_r <= {DATA_W{1'b0}};
    end else begin
      dly_r[0] <= {vid.i_hsync, vid.i_vsync, vid.i_de};
      for (int k = 1; k < L; k++) begin
        dly_r[k] <= dly_r[k-1];
      end
      pix_r <= pix_next_s;
    end
  end

  // Frame max: decided one cycle ahead so the pulse lands on the o_vsync rise
  // and includes the pixel presented in that same cycle.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      run_max_r       <= {DATA_W{1'b0}};
      frame_max_r     <= {DATA_W{1'b0}};
      frame_max_vld_r <= 1'b0;
    end else if (vs_rise_next_s) begin
      frame_max_r     <= pick(1'b1, run_max_r, pix_next_s);
      frame_max_vld_r <= 1'b1;
      run_max_r       <= {DATA_W{1'b0}};
    end else begin
      frame_max_r     <= frame_max_r;
      frame_max_vld_r <= 1'b0;
      run_max_r       <= pick(1'b1, run_max_r, pix_next_s);
    end
  end

  assign vid.o_pix           = pix_r;
  assign vid.o_hsync         = dly_r[L-1][2];
  assign vid.o_vsync         = dly_r[L-1][1];
  assign vid.o_de            = dly_r[L-1][0];
  assign vid.o_frame_max     = frame_max_r;
  assign vid.o_frame_max_vld = frame_max_vld_r;

endmodule

// File: tb/tb_rgb_dark_win.sv
// Directed bench for rgb_dark_win: WIN=1 and WIN=3 instances share one stimulus.
module tb_rgb_dark_win;

  logic        pixelclk = 1'b0;
  logic        reset;
  logic        mode;
  logic [23:0] rgb;
  logic        hs, vs, de;

  rgb_dark_win_if #(.DATA_W(8)) if1 ();
  rgb_dark_win_if #(.DATA_W(8)) if3 ();

  assign if1.i_mode = mode;  assign if3.i_mode = mode;
  assign if1.i_rgb = rgb;    assign if3.i_rgb = rgb;
  assign if1.i_hsync = hs;   assign if3.i_hsync = hs;
  assign if1.i_vsync = vs;   assign if3.i_vsync = vs;
  assign if1.i_de = de;      assign if3.i_de = de;

  rgb_dark_win #(.DATA_W(8), .WIN(1)) u1 (.pixelclk(pixelclk), .reset(reset), .vid(if1));
  rgb_dark_win #(.DATA_W(8), .WIN(3)) u3 (.pixelclk(pixelclk), .reset(reset), .vid(if3));

  always #5 pixelclk = ~pixelclk;

  int cyc = 0;
  always @(posedge pixelclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed WIN=3 output pixels with their cycle stamps.
  int q_pix[$];
  int q_cyc[$];
  bit hs_prev = 1'b0;
  int hs_rise_cyc = -1;
  always @(negedge pixelclk) begin
    if (if3.o_de === 1'b1) begin
      q_pix.push_back(int'(if3.o_pix));
      q_cyc.push_back(cyc);
    end
    if (if3.o_hsync === 1'b1 && !hs_prev) hs_rise_cyc = cyc;
    hs_prev = (if3.o_hsync === 1'b1);
  end

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic px(input logic [7:0] v);
    rgb = {v, 8'hFF, v};
    de  = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    de  = 1'b0;
    rgb = 24'h0;
    repeat (n) tick();
  endtask

  task automatic clear_q();
    q_pix.delete();
    q_cyc.delete();
  endtask

  task automatic check_line(input string tag, input int start, input int n,
                            input int e0, input int e1, input int e2, input int e3, input int e4);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    check({tag, "_count"}, q_pix.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_pix%0d", tag, i), (i < q_pix.size()) ? q_pix[i] : -1, e[i]);
    end
    check({tag, "_lat"}, (q_cyc.size() > 0) ? q_cyc[0] : -1, start + 4);
  endtask

  task automatic vs_pulse(input string tag, input logic [7:0] exp_max);
    int k;
    bit found;
    vs = 1'b1;
    de = 1'b0;
    tick();
    vs = 1'b0;
    k = 0;
    found = 1'b0;
    for (int i = 2; i <= 20 && !found; i++) begin
      tick();
      if (if3.o_vsync === 1'b1) begin
        found = 1'b1;
        k = i;
      end
    end
    check({tag, "_seen"}, found, 1);
    check({tag, "_lat"}, k, 4);
    check({tag, "_vld"}, if3.o_frame_max_vld, 1);
    check({tag, "_max"}, if3.o_frame_max, exp_max);
    tick();
    check({tag, "_vld_off"}, if3.o_frame_max_vld, 0);
    check({tag, "_hold"}, if3.o_frame_max, exp_max);
  endtask

  int start;
  int hs_start;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mode = 1'($urandom);
      rgb  = 24'($urandom);
      hs   = 1'($urandom);
      vs   = 1'($urandom);
      de   = 1'($urandom);
      tick();
    end
    check("rst_pix", if3.o_pix, 0);
    check("rst_de", if3.o_de, 0);
    check("rst_hs", if3.o_hsync, 0);
    check("rst_vs", if3.o_vsync, 0);
    check("rst_fmax", if3.o_frame_max, 0);
    check("rst_vld", if3.o_frame_max_vld, 0);
    check("rst_pix1", if1.o_pix, 0);

    reset = 1'b0;
    mode = 1'b0; rgb = 24'h0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (3) tick();
    check("idle_pix", if3.o_pix, 0);
    check("idle_fmax", if3.o_frame_max, 0);
    check("idle_vld", if3.o_frame_max_vld, 0);

    // Dark channel of 0x8040C0 is 0x40; WIN=1 latency 3, WIN=3 latency 4.
    rgb = 24'h8040C0; de = 1'b1; tick();
    idle(2);
    check("w1_dark_de", if1.o_de, 1);
    check("w1_dark_pix", if1.o_pix, 8'h40);
    tick();
    check("w3_dark_de", if3.o_de, 1);
    check("w3_dark_pix", if3.o_pix, 8'h40);
    check("w1_after_de", if1.o_de, 0);
    check("w1_after_pix", if1.o_pix, 0);
    idle(4);

    // Latch bright mode; first report covers the partial frame since reset.
    mode = 1'b1;
    vs_pulse("fm_first", 8'h40);
    idle(2);
    rgb = 24'h8040C0; de = 1'b1; tick();
    idle(2);
    check("w1_bright_pix", if1.o_pix, 8'hC0);
    tick();
    check("w3_bright_pix", if3.o_pix, 8'hC0);
    idle(4);

    mode = 1'b0;
    vs_pulse("fm_c0", 8'hC0);
    idle(2);

    // Window: 10,5,20,30,1 -> 5,5,5,1,1.
    clear_q();
    hs_start = cyc;
    hs = 1'b1; tick(); tick(); hs = 1'b0;
    start = cyc;
    px(8'd10); px(8'd5); px(8'd20); px(8'd30); px(8'd1);
    idle(8);
    check_line("win", start, 5, 5, 5, 5, 1, 1);
    check("hs_lat", hs_rise_cyc, hs_start + 4);

    // Line isolation: trailing 0 must not leak into the next line.
    clear_q();
    start = cyc;
    px(8'd60); px(8'd0);
    idle(2);
    px(8'd200); px(8'd200); px(8'd200);
    idle(8);
    check_line("iso", start, 5, 0, 0, 200, 200, 200);

    vs_pulse("fm_c8", 8'hC8);
    mode = 1'b1;
    idle(2);
    clear_q();
    start = cyc;
    px(8'h9A); px(8'h9A); px(8'h9A); px(8'h05);
    idle(8);
    check_line("latch", start, 4, 8'h9A, 8'h9A, 8'h05, 8'h05, 0);
    mode = 1'b0;
    vs_pulse("fm_9a", 8'h9A);
    px(8'h20); px(8'h20);
    idle(8);
    vs_pulse("fm_20", 8'h20);

    // Reset for one cycle inside an active line.
    idle(2);
    clear_q();
    px(8'hF0); px(8'hF0);
    reset = 1'b1; rgb = {8'hF0, 8'hFF, 8'hF0}; de = 1'b1;
    tick();
    reset = 1'b0;
    de = 1'b0; rgb = 24'h0;
    check("mid_rst_pix", if3.o_pix, 0);
    check("mid_rst_de", if3.o_de, 0);
    check("mid_rst_fmax", if3.o_frame_max, 0);
    check("mid_rst_pix1", if1.o_pix, 0);
    idle(8);
    check("mid_rst_stale", q_pix.size(), 0);
    px(8'h11);
    idle(6);
    vs_pulse("fm_rst", 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
